// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory access controller.
package dm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StDone = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        SzByte = 2'b00,
        SzHalf = 2'b01,
        SzWord = 2'b10
    } size_e;

    // Big-endian lanes: bit 3 enables bits 31:24, i.e. byte offset 0.
    localparam logic [3:0] MASK_B0 = 4'b1000;
    localparam logic [3:0] MASK_B1 = 4'b0100;
    localparam logic [3:0] MASK_B2 = 4'b0010;
    localparam logic [3:0] MASK_B3 = 4'b0001;
    localparam logic [3:0] MASK_H0 = 4'b1100;
    localparam logic [3:0] MASK_H1 = 4'b0011;
    localparam logic [3:0] MASK_W  = 4'b1111;

    // Byte wins over half when both are set.
    function automatic size_e decode_size(input logic is_byte, input logic is_half);
        if (is_byte) begin
            return SzByte;
        end
        if (is_half) begin
            return SzHalf;
        end
        return SzWord;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// CPU-side and memory-side signals of the access controller.
// master = controller view, slave = environment (CPU and memory) view.
interface dm_access_ctrl_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_byte;
    logic              cpu_half;
    logic              cpu_signed;
    logic [31:0]       cpu_wdata;
    logic              cpu_busy;
    logic              cpu_done;
    logic [31:0]       cpu_rdata;
    logic              cpu_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_byte, cpu_half, cpu_signed, cpu_wdata,
        input  mem_rdata, mem_ack,
        output cpu_busy, cpu_done, cpu_rdata, cpu_err,
        output mem_req, mem_we, mem_addr, mem_mask, mem_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_byte, cpu_half, cpu_signed, cpu_wdata,
        output mem_rdata, mem_ack,
        input  cpu_busy, cpu_done, cpu_rdata, cpu_err,
        input  mem_req, mem_we, mem_addr, mem_mask, mem_wdata
    );
endinterface

// File: rtl/dm_access_ctrl_lane_align.sv
// Byte-lane mask generation, store-data lane alignment and load extract/extend.
module dm_lane_align
    import dm_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_aligned,
    input  size_e       ld_size,
    input  logic [3:0]  ld_mask,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_aligned
);

    always_comb begin
        mask = MASK_W;
        case (size)
            SzByte: begin
                case (addr_lo)
                    2'b00:   mask = MASK_B0;
                    2'b01:   mask = MASK_B1;
                    2'b10:   mask = MASK_B2;
                    default: mask = MASK_B3;
                endcase
            end
            SzHalf:  mask = addr_lo[1] ? MASK_H1 : MASK_H0;
            default: mask = MASK_W;
        endcase
    end

    always_comb begin
        wdata_aligned = wdata;
        case (mask)
            MASK_B0: wdata_aligned = wdata << 24;
            MASK_B1: wdata_aligned = wdata << 16;
            MASK_B2: wdata_aligned = wdata << 8;
            MASK_H0: wdata_aligned = wdata << 16;
            default: wdata_aligned = wdata;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[7:0];
        case (ld_mask)
            MASK_B0: ld_byte = rdata[31:24];
            MASK_B1: ld_byte = rdata[23:16];
            MASK_B2: ld_byte = rdata[15:8];
            default: ld_byte = rdata[7:0];
        endcase
        ld_half = (ld_mask == MASK_H0) ? rdata[31:16] : rdata[15:0];

        rdata_aligned = rdata;
        case (ld_size)
            SzByte:  rdata_aligned = {{24{ld_signed & ld_byte[7]}}, ld_byte};
            SzHalf:  rdata_aligned = {{16{ld_signed & ld_half[15]}}, ld_half};
            default: rdata_aligned = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: latches a CPU load/store, runs the mem req/ack handshake
// with a timeout. Define DM_ALIGN_CHECK_EN to fail misaligned half/word accesses without a bus cycle.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input logic              clk,
    input logic              rst_n,
    dm_access_ctrl_if.master bus
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-3:0] addr_q;
    logic [3:0]        mask_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              signed_q;
    size_e             size_q;
    logic [31:0]       cpu_rdata_q;

    logic              capture;
    logic              ack_take;
    logic              misalign;
    size_e             req_size;
    logic [3:0]        req_mask;
    logic [31:0]       req_wdata;
    logic [31:0]       ld_data;

    assign req_size = decode_size(bus.cpu_byte, bus.cpu_half);

    dm_lane_align u_align (
        .size          (req_size),
        .addr_lo       (bus.cpu_addr[1:0]),
        .wdata         (bus.cpu_wdata),
        .mask          (req_mask),
        .wdata_aligned (req_wdata),
        .ld_size       (size_q),
        .ld_mask       (mask_q),
        .ld_signed     (signed_q),
        .rdata         (bus.mem_rdata),
        .rdata_aligned (ld_data)
    );

`ifdef DM_ALIGN_CHECK_EN
    assign misalign = ((req_size == SzHalf) && bus.cpu_addr[0]) ||
                      ((req_size == SzWord) && (bus.cpu_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        capture  = 1'b0;
        ack_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    capture = 1'b1;
                    cnt_d   = 8'd0;
                    err_d   = misalign;
                    state_d = misalign ? StDone : StReq;
                end
            end
            StReq: begin
                // An ack always beats the timeout in the same cycle.
                if (bus.mem_ack) begin
                    ack_take = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            mask_q   <= 4'b0000;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= SzByte;
        end else if (capture) begin
            addr_q   <= bus.cpu_addr[ADDR_W-1:2];
            mask_q   <= req_mask;
            wdata_q  <= req_wdata;
            we_q     <= bus.cpu_we;
            signed_q <= bus.cpu_signed;
            size_q   <= req_size;
        end
    end

    // Load result is registered on the ack edge so it is valid during the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rdata_q <= 32'd0;
        end else if (ack_take && !we_q) begin
            cpu_rdata_q <= ld_data;
        end
    end

    always_comb begin
        bus.cpu_busy  = (state_q != StIdle);
        bus.cpu_done  = (state_q == StDone);
        bus.cpu_err   = (state_q == StDone) && err_q;
        bus.cpu_rdata = cpu_rdata_q;
        bus.mem_req   = (state_q == StReq);
        bus.mem_we    = (state_q == StReq) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_mask  = mask_q;
        bus.mem_wdata = wdata_q;
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl (TIMEOUT=15).
module tb_dm_access_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    dm_access_ctrl_if #(.ADDR_W(32)) bus ();

    dm_access_ctrl #(
        .ADDR_W  (32),
        .TIMEOUT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Presents one request for a single cycle; returns at the negedge of the first cycle after acceptance.
    task automatic start_req(input logic we, input logic [31:0] addr, input logic by,
                             input logic hf, input logic sg, input logic [31:0] wd);
        @(negedge clk);
        bus.cpu_req    = 1'b1;
        bus.cpu_we     = we;
        bus.cpu_addr   = addr;
        bus.cpu_byte   = by;
        bus.cpu_half   = hf;
        bus.cpu_signed = sg;
        bus.cpu_wdata  = wd;
        @(negedge clk);
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus.cpu_busy, bus.cpu_done, bus.cpu_err, bus.mem_req, bus.mem_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.cpu_busy, bus.cpu_done, bus.cpu_err, bus.mem_req, bus.mem_we});
        end
        n_checks++;
        if ({bus.mem_mask, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata} !== 98'd0) begin
            n_fail++;
            $display("FAIL reset_data: mask %b addr %h wdata %h rdata %h want all 0",
                     bus.mem_mask, bus.mem_addr, bus.mem_wdata, bus.cpu_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_byte_store();
        start_req(1'b1, 32'h102, 1'b1, 1'b0, 1'b0, 32'h0000_00AB);
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL st_req: got req %b we %b want 1 1", bus.mem_req, bus.mem_we);
        end
        n_checks++;
        if (bus.mem_addr !== 30'h40 || bus.mem_mask !== 4'b0010) begin
            n_fail++;
            $display("FAIL st_addr_mask: got %h %b want 40 0010", bus.mem_addr, bus.mem_mask);
        end
        n_checks++;
        if (bus.mem_wdata !== 32'h0000_AB00) begin
            n_fail++;
            $display("FAIL st_wdata: got %h want 0000ab00", bus.mem_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.cpu_done !== 1'b0) begin
            n_fail++;
            $display("FAIL st_wait: got req %b done %b want 1 0", bus.mem_req, bus.cpu_done);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL st_done_c5: got done %b err %b req %b want 1 0 0",
                     bus.cpu_done, bus.cpu_err, bus.mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cpu_done !== 1'b0 || bus.cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL st_idle: got done %b busy %b want 0 0", bus.cpu_done, bus.cpu_busy);
        end
    endtask

    task automatic test_byte_load();
        start_req(1'b0, 32'h3, 1'b1, 1'b0, 1'b1, 32'h0);
        n_checks++;
        if (bus.mem_mask !== 4'b0001 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL ldb_mask: got %b we %b want 0001 0", bus.mem_mask, bus.mem_we);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1234_56F0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL ldb_signed: got done %b rdata %h want 1 fffffff0",
                     bus.cpu_done, bus.cpu_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cpu_rdata !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL ldb_hold: got %h want fffffff0", bus.cpu_rdata);
        end
        start_req(1'b0, 32'h3, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== 32'h0000_00F0) begin
            n_fail++;
            $display("FAIL ldb_unsigned: got done %b rdata %h want 1 000000f0",
                     bus.cpu_done, bus.cpu_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_half_load();
        bus.mem_rdata = 32'h8001_7FFF;
        start_req(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0);
        n_checks++;
        if (bus.mem_mask !== 4'b1100) begin
            n_fail++;
            $display("FAIL ldh0_mask: got %b want 1100", bus.mem_mask);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_rdata !== 32'hFFFF_8001) begin
            n_fail++;
            $display("FAIL ldh0_data: got %h want ffff8001", bus.cpu_rdata);
        end
        @(negedge clk);
        start_req(1'b0, 32'h2, 1'b0, 1'b1, 1'b1, 32'h0);
        n_checks++;
        if (bus.mem_mask !== 4'b0011) begin
            n_fail++;
            $display("FAIL ldh1_mask: got %b want 0011", bus.mem_mask);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_rdata !== 32'h0000_7FFF) begin
            n_fail++;
            $display("FAIL ldh1_data: got %h want 00007fff", bus.cpu_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int  req_cycles = 0;
        logic seen_done = 1'b0;
        start_req(1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            if (bus.mem_req === 1'b1) req_cycles++;
            if (bus.cpu_done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (seen_done !== 1'b1 || req_cycles != 15) begin
            n_fail++;
            $display("FAIL to_req_cycles: got done %b cycles %0d want 1 15", seen_done, req_cycles);
        end
        n_checks++;
        if (bus.cpu_err !== 1'b1 || bus.cpu_rdata !== 32'h0000_7FFF) begin
            n_fail++;
            $display("FAIL to_err: got err %b rdata %h want 1 00007fff", bus.cpu_err, bus.cpu_rdata);
        end
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_busy !== 1'b0 || bus.cpu_done !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ack: got busy %b done %b req %b want 0 0 0",
                     bus.cpu_busy, bus.cpu_done, bus.mem_req);
        end
    endtask

    task automatic test_busy_ignore();
        start_req(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h1122_3344);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h80;
        bus.cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        n_checks++;
        if (bus.mem_addr !== 30'h10 || bus.mem_wdata !== 32'h1122_3344 || bus.mem_mask !== 4'b1111) begin
            n_fail++;
            $display("FAIL busy_ignore: got %h %h %b want 10 11223344 1111",
                     bus.mem_addr, bus.mem_wdata, bus.mem_mask);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_done: got done %b err %b want 1 0", bus.cpu_done, bus.cpu_err);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        logic done_seen = 1'b0;
        start_req(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'hA5A5_A5A5);
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got req %b want 1", bus.mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: got req %b busy %b want 0 0", bus.mem_req, bus.cpu_busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.cpu_done === 1'b1) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.cpu_done === 1'b1) done_seen = 1'b1;
        n_checks++;
        if (done_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_done: got done seen %b want 0", done_seen);
        end
        bus.mem_rdata = 32'hCAFE_F00D;
        start_req(1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rst_after: got done %b err %b rdata %h want 1 0 cafef00d",
                     bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_align();
        bus.mem_rdata = 32'h55AA_55AA;
        start_req(1'b0, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
`ifdef DM_ALIGN_CHECK_EN
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL align_err: got done %b err %b req %b want 1 1 0",
                     bus.cpu_done, bus.cpu_err, bus.mem_req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.cpu_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL align_idle: got req %b busy %b want 0 0", bus.mem_req, bus.cpu_busy);
        end
`else
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_mask !== 4'b1111 || bus.mem_addr !== 30'h1) begin
            n_fail++;
            $display("FAIL noalign_req: got req %b mask %b addr %h want 1 1111 1",
                     bus.mem_req, bus.mem_mask, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        n_checks++;
        if (bus.cpu_done !== 1'b1 || bus.cpu_err !== 1'b0 || bus.cpu_rdata !== 32'h55AA_55AA) begin
            n_fail++;
            $display("FAIL noalign_done: got done %b err %b rdata %h want 1 0 55aa55aa",
                     bus.cpu_done, bus.cpu_err, bus.cpu_rdata);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = 32'h0;
        bus.cpu_byte   = 1'b0;
        bus.cpu_half   = 1'b0;
        bus.cpu_signed = 1'b0;
        bus.cpu_wdata  = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ack    = 1'b0;
        test_reset();
        test_byte_store();
        test_byte_load();
        test_half_load();
        test_timeout();
        test_busy_ignore();
        test_reset_mid_req();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
